tmr_fault_monitor: RTL and testbench

- Downstream companion to the 2-of-3 voter. It receives the same three lane bits the voter receives, plus the voter's error flag.
- Identifies which lane is the minority, keeps per-lane saturating error counts and runs a per-lane health state machine.
- Latches failed lanes into a mask. Cross-checks the voter's own error output against an independent recomputation.
- Sits between the voter and system status/scrub logic.

---
 rtl/tmr_pkg.sv | 21 ++
 rtl/tmr_lane_tracker.sv | 82 ++++++++
 rtl/tmr_fault_monitor.sv | 117 +++++++++++
 tb/tb_tmr_fault_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault monitor: lane identifiers,
// the per-lane health state encoding and a small popcount helper.
package tmr_pkg;

  localparam logic [1:0] LANE_NONE = 2'd0;
  localparam logic [1:0] LANE_A    = 2'd1;
  localparam logic [1:0] LANE_B    = 2'd2;
  localparam logic [1:0] LANE_C    = 2'd3;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } lane_state_t;

  // Number of set bits in a 3-bit lane mask.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_lane_tracker.sv
// Health tracker for a single TMR lane: persistence FSM, run counter and a
// saturating miscompare counter. Optional macro TMR_MON_IRQ_EN adds the
// fail_entry strobe used by the parent to build its interrupt pulse.
module tmr_lane_tracker
  import tmr_pkg::*;
#(
  parameter int PERSIST_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset_n_in,
  input  logic             clear_in,
  input  logic             miscompare,
  output logic [CNT_W-1:0] count,
`ifdef TMR_MON_IRQ_EN
  output logic             fail_entry,
`endif
  output logic             failed
);

  localparam int RUN_W = $clog2(PERSIST_CYCLES + 1);
  localparam logic [RUN_W-1:0] PERSIST_LIM = RUN_W'(PERSIST_CYCLES);

  lane_state_t      state;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             reach_limit;

  assign run_inc     = run + RUN_W'(1);
  assign reach_limit = (run_inc == PERSIST_LIM);

  // Persistence FSM: a lane must be the minority on PERSIST_CYCLES
  // consecutive cycles before it is latched as FAILED; clear beats everything.
  always_ff @(posedge clock) begin
    if (!reset_n_in || clear_in) begin
      state <= HEALTHY;
      run   <= '0;
    end else begin
      case (state)
        HEALTHY: begin
          if (miscompare) begin
            run   <= RUN_W'(1);
            state <= (PERSIST_CYCLES == 1) ? FAILED : SUSPECT;
          end
        end
        SUSPECT: begin
          if (miscompare) begin
            run <= run_inc;
            if (reach_limit) state <= FAILED;
          end else begin
            state <= HEALTHY;
            run   <= '0;
          end
        end
        FAILED: state <= FAILED;
        default: begin
          state <= HEALTHY;
          run   <= '0;
        end
      endcase
    end
  end

  // Saturating miscompare counter; keeps counting after FAILED, never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n_in || clear_in) begin
      count <= '0;
    end else if (miscompare && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign failed = (state == FAILED);

`ifdef TMR_MON_IRQ_EN
  // High on the cycle whose closing edge moves this lane into FAILED.
  assign fail_entry = reset_n_in && !clear_in && miscompare &&
                      (((state == HEALTHY) && (PERSIST_CYCLES == 1)) ||
                       ((state == SUSPECT) && reach_limit));
`endif

endmodule

// File: rtl/tmr_fault_monitor.sv
// Companion to the 2-of-3 voter: finds the minority lane, tracks per-lane
// health, latches failed lanes and cross-checks the voter's error flag.
// Optional macro TMR_MON_IRQ_EN adds the irq_out pulse output.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int PERSIST_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset_n_in,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             c_in,
  input  logic             v_error_in,
  input  logic             clear_in,
  output logic [1:0]       fault_lane_out,
  output logic [CNT_W-1:0] err_cnt_a_out,
  output logic [CNT_W-1:0] err_cnt_b_out,
  output logic [CNT_W-1:0] err_cnt_c_out,
  output logic [2:0]       fail_mask_out,
  output logic             alarm_out,
  output logic             degraded_out,
  output logic             voter_mismatch_out
`ifdef TMR_MON_IRQ_EN
  , output logic           irq_out
`endif
);

  logic             a_r, b_r, c_r;
  logic [1:0]       fault_lane;
  logic             internal_err;
  logic [2:0]       miscompare;
  logic [2:0]       failed;
  logic [CNT_W-1:0] lane_cnt [3];

  // Lane input stage, aligned with the voter's one-cycle input latency.
  always_ff @(posedge clock) begin
    if (!reset_n_in) begin
      a_r <= 1'b0;
      b_r <= 1'b0;
      c_r <= 1'b0;
    end else begin
      a_r <= a_in;
      b_r <= b_in;
      c_r <= c_in;
    end
  end

  // Minority-lane classification from the registered lanes.
  always_comb begin
    fault_lane = LANE_NONE;
    if (!((a_r == b_r) && (b_r == c_r))) begin
      if (b_r == c_r)      fault_lane = LANE_A;
      else if (a_r == c_r) fault_lane = LANE_B;
      else                 fault_lane = LANE_C;
    end
  end

  assign internal_err  = (fault_lane != LANE_NONE);
  assign miscompare[0] = (fault_lane == LANE_A);
  assign miscompare[1] = (fault_lane == LANE_B);
  assign miscompare[2] = (fault_lane == LANE_C);

`ifdef TMR_MON_IRQ_EN
  logic [2:0] fail_entry;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_lane
    tmr_lane_tracker #(
      .PERSIST_CYCLES(PERSIST_CYCLES),
      .CNT_W         (CNT_W)
    ) u_tracker (
      .clock      (clock),
      .reset_n_in (reset_n_in),
      .clear_in   (clear_in),
      .miscompare (miscompare[i]),
      .count      (lane_cnt[i]),
`ifdef TMR_MON_IRQ_EN
      .fail_entry (fail_entry[i]),
`endif
      .failed     (failed[i])
    );
  end

  // Sticky flag: voter error disagreed with our own recomputation.
  always_ff @(posedge clock) begin
    if (!reset_n_in || clear_in) begin
      voter_mismatch_out <= 1'b0;
    end else if (v_error_in != internal_err) begin
      voter_mismatch_out <= 1'b1;
    end
  end

`ifdef TMR_MON_IRQ_EN
  logic mismatch_entry;
  assign mismatch_entry = !voter_mismatch_out && (v_error_in != internal_err);

  // One registered pulse whenever a mask bit or the mismatch flag rises.
  always_ff @(posedge clock) begin
    if (!reset_n_in || clear_in) begin
      irq_out <= 1'b0;
    end else begin
      irq_out <= (|fail_entry) || mismatch_entry;
    end
  end
`endif

  assign fault_lane_out = fault_lane;
  assign err_cnt_a_out  = lane_cnt[0];
  assign err_cnt_b_out  = lane_cnt[1];
  assign err_cnt_c_out  = lane_cnt[2];
  assign fail_mask_out  = failed;
  assign alarm_out      = |failed;
  assign degraded_out   = (popcount3(failed) >= 2'd2);

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed self-checking bench for tmr_fault_monitor (PERSIST_CYCLES = 4,
// CNT_W = 8). irq_out checks are compiled in only with TMR_MON_IRQ_EN.
module tb_tmr_fault_monitor;

  logic       clock;
  logic       reset_n_in;
  logic       a_in, b_in, c_in;
  logic       v_error_in;
  logic       clear_in;
  logic [1:0] fault_lane_out;
  logic [7:0] err_cnt_a_out, err_cnt_b_out, err_cnt_c_out;
  logic [2:0] fail_mask_out;
  logic       alarm_out;
  logic       degraded_out;
  logic       voter_mismatch_out;
`ifdef TMR_MON_IRQ_EN
  logic       irq_out;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Lane values currently held in the DUT's input registers.
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  tmr_fault_monitor #(
    .PERSIST_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clock              (clock),
    .reset_n_in         (reset_n_in),
    .a_in               (a_in),
    .b_in               (b_in),
    .c_in               (c_in),
    .v_error_in         (v_error_in),
    .clear_in           (clear_in),
    .fault_lane_out     (fault_lane_out),
    .err_cnt_a_out      (err_cnt_a_out),
    .err_cnt_b_out      (err_cnt_b_out),
    .err_cnt_c_out      (err_cnt_c_out),
    .fail_mask_out      (fail_mask_out),
    .alarm_out          (alarm_out),
    .degraded_out       (degraded_out),
    .voter_mismatch_out (voter_mismatch_out)
`ifdef TMR_MON_IRQ_EN
    , .irq_out          (irq_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Drive one cycle of lanes; v_error_in models a correct voter unless
  // bad_voter flips it. Returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic clr, input logic bad_voter);
    a_in       = a;
    b_in       = b;
    c_in       = c;
    clear_in   = clr;
    v_error_in = !((prev_a == prev_b) && (prev_b == prev_c)) ^ bad_voter;
    @(posedge clock);
    #1;
    if (!reset_n_in) begin
      prev_a = 1'b0; prev_b = 1'b0; prev_c = 1'b0;
    end else begin
      prev_a = a; prev_b = b; prev_c = c;
    end
    clear_in = 1'b0;
  endtask

  initial begin
    reset_n_in = 1'b0;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0;
    v_error_in = 1'b0; clear_in = 1'b0;

    // Test 1: reset state, then all lanes agree for 20 cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_fault_lane", 32'(fault_lane_out), 32'd0);
    checkOutput("rst_cnt_a", 32'(err_cnt_a_out), 32'd0);
    checkOutput("rst_cnt_b", 32'(err_cnt_b_out), 32'd0);
    checkOutput("rst_cnt_c", 32'(err_cnt_c_out), 32'd0);
    checkOutput("rst_mask", 32'(fail_mask_out), 32'd0);
    checkOutput("rst_alarm", 32'(alarm_out), 32'd0);
    checkOutput("rst_degraded", 32'(degraded_out), 32'd0);
    checkOutput("rst_mismatch", 32'(voter_mismatch_out), 32'd0);
`ifdef TMR_MON_IRQ_EN
    checkOutput("rst_irq", 32'(irq_out), 32'd0);
`endif
    reset_n_in = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_fault_lane", 32'(fault_lane_out), 32'd0);
    checkOutput("t1_cnt_a", 32'(err_cnt_a_out), 32'd0);
    checkOutput("t1_cnt_b", 32'(err_cnt_b_out), 32'd0);
    checkOutput("t1_cnt_c", 32'(err_cnt_c_out), 32'd0);
    checkOutput("t1_mask", 32'(fail_mask_out), 32'd0);
    checkOutput("t1_mismatch", 32'(voter_mismatch_out), 32'd0);

    // Test 2: B minority for 3 cycles, one short of failing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_fault_lane_b", 32'(fault_lane_out), 32'd2);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_fault_lane_none", 32'(fault_lane_out), 32'd0);
    checkOutput("t2_cnt_b", 32'(err_cnt_b_out), 32'd3);
    checkOutput("t2_mask", 32'(fail_mask_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // One more B miscompare must start a fresh run, not finish the old one.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_cnt_b_4", 32'(err_cnt_b_out), 32'd4);
    checkOutput("t2_mask_after_rerun", 32'(fail_mask_out), 32'd0);

    // Test 3: C minority 4 consecutive cycles -> C FAILED.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_fault_lane_c", 32'(fault_lane_out), 32'd3);
    checkOutput("t3_mask_not_yet", 32'(fail_mask_out), 32'd0);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t3_irq_not_yet", 32'(irq_out), 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_cnt_c", 32'(err_cnt_c_out), 32'd4);
    checkOutput("t3_mask", 32'(fail_mask_out), 32'd4);
    checkOutput("t3_alarm", 32'(alarm_out), 32'd1);
    checkOutput("t3_degraded", 32'(degraded_out), 32'd0);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t3_irq_pulse", 32'(irq_out), 32'd1);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_mask_sticky", 32'(fail_mask_out), 32'd4);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t3_irq_single", 32'(irq_out), 32'd0);
`endif

    // Test 4: A minority 300 cycles -> counter saturates, A FAILED, degraded.
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 5) begin
        checkOutput("t4_mask_a", 32'(fail_mask_out), 32'd5);
        checkOutput("t4_degraded", 32'(degraded_out), 32'd1);
      end
      if (i == 256) checkOutput("t4_cnt_a_255", 32'(err_cnt_a_out), 32'd255);
      if (i == 257) checkOutput("t4_cnt_a_sat", 32'(err_cnt_a_out), 32'd255);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_cnt_a_end", 32'(err_cnt_a_out), 32'd255);
    checkOutput("t4_mask_end", 32'(fail_mask_out), 32'd5);
    checkOutput("t4_mismatch", 32'(voter_mismatch_out), 32'd0);

    // Test 5: clear, then a lying voter sets the sticky mismatch flag.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_clr_cnt_a", 32'(err_cnt_a_out), 32'd0);
    checkOutput("t5_clr_cnt_c", 32'(err_cnt_c_out), 32'd0);
    checkOutput("t5_clr_mask", 32'(fail_mask_out), 32'd0);
    checkOutput("t5_clr_degraded", 32'(degraded_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_fault_lane_a", 32'(fault_lane_out), 32'd1);
    checkOutput("t5_mismatch_pre", 32'(voter_mismatch_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_mismatch_set", 32'(voter_mismatch_out), 32'd1);
    checkOutput("t5_cnt_a_1", 32'(err_cnt_a_out), 32'd1);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t5_irq_pulse", 32'(irq_out), 32'd1);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_mismatch_held", 32'(voter_mismatch_out), 32'd1);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t5_irq_low", 32'(irq_out), 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_mismatch_clr", 32'(voter_mismatch_out), 32'd0);
    checkOutput("t5_cnt_a_clr", 32'(err_cnt_a_out), 32'd0);

    // Test 6a: clear in the same cycle B is minority -> clear wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_fault_lane_b", 32'(fault_lane_out), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_clr_wins_cnt_b", 32'(err_cnt_b_out), 32'd0);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t6_clr_irq", 32'(irq_out), 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_cnt_b_stays", 32'(err_cnt_b_out), 32'd0);

    // Test 6b: reset while C is SUSPECT discards the run.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_cnt_c_pre", 32'(err_cnt_c_out), 32'd2);
    reset_n_in = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n_in = 1'b1;
    checkOutput("t6_rst_cnt_c", 32'(err_cnt_c_out), 32'd0);
    checkOutput("t6_rst_fault_lane", 32'(fault_lane_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_post_rst_cnt_c", 32'(err_cnt_c_out), 32'd2);
    checkOutput("t6_post_rst_mask", 32'(fail_mask_out), 32'd0);
    checkOutput("t6_post_rst_mismatch", 32'(voter_mismatch_out), 32'd0);
`ifdef TMR_MON_IRQ_EN
    checkOutput("t6_post_rst_irq", 32'(irq_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
